// File: rtl/rbcp_pkg.sv
// Shared constants for the RBCP register responder: bus widths, register map
// offsets and the supported ack-latency range.
package rbcp_pkg;

  localparam int RBCP_DW = 8;
  localparam int RBCP_AW = 32;

  localparam int ACK_LAT_MIN = 1;
  localparam int ACK_LAT_MAX = 4;

  localparam logic [7:0] OFS_ID      = 8'h00;
  localparam logic [7:0] OFS_SCRATCH = 8'h01;
  localparam logic [7:0] OFS_CTRL    = 8'h02;
  localparam logic [7:0] OFS_ERR     = 8'h03;
  localparam logic [7:0] OFS_RW_BASE = 8'h10;
  localparam logic [7:0] OFS_RO_BASE = 8'h40;

endpackage

// File: rtl/rbcp_reg_slave_if.sv
// SiTCP RBCP initiator-to-responder bus. The initiator (SiTCP) drives the
// strobes and address; the responder drives ack and read data.
interface rbcp_reg_slave_if;
  import rbcp_pkg::*;

  logic               rbcp_act;
  logic [RBCP_AW-1:0] rbcp_addr;
  logic [RBCP_DW-1:0] rbcp_wd;
  logic               rbcp_we;
  logic               rbcp_re;
  logic               rbcp_ack;
  logic [RBCP_DW-1:0] rbcp_rd;

  modport master (
    output rbcp_act, rbcp_addr, rbcp_wd, rbcp_we, rbcp_re,
    input  rbcp_ack, rbcp_rd
  );

  modport slave (
    input  rbcp_act, rbcp_addr, rbcp_wd, rbcp_we, rbcp_re,
    output rbcp_ack, rbcp_rd
  );

endinterface

// File: rtl/rbcp_ack_pipe.sv
// Delays the accepted-access valid bit and its read byte by DEPTH cycles.
// Flush drops everything in flight; pending covers acceptance through ack.
module rbcp_ack_pipe
  import rbcp_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [RBCP_DW-1:0] in_data,
  output logic               ack,
  output logic [RBCP_DW-1:0] rd,
  output logic               pending
);

  localparam int D = (DEPTH < ACK_LAT_MIN) ? ACK_LAT_MIN :
                     (DEPTH > ACK_LAT_MAX) ? ACK_LAT_MAX : DEPTH;

  logic [D-1:0]       vld;
  logic [RBCP_DW-1:0] dat [D];

  // Data is zeroed whenever its slot is empty so rd reads 0x00 outside ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < D; i++) dat[i] <= '0;
    end else if (flush) begin
      vld <= '0;
      for (int i = 0; i < D; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < D; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign ack     = vld[D-1];
  assign rd      = dat[D-1];
  assign pending = |vld;

endmodule

// File: rtl/rbcp_reg_slave.sv
// RBCP responder: decodes a 256-byte window at BASE_ADDR into ID, scratch,
// control pulses, error flag, RW config bytes and RO status bytes.
module rbcp_reg_slave
  import rbcp_pkg::*;
#(
  parameter logic [RBCP_AW-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                 NUM_RW      = 8,
  parameter int                 NUM_RO      = 4,
  parameter int                 ACK_LATENCY = 1,
  parameter logic [RBCP_DW-1:0] ID_VALUE    = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rbcp_reg_slave_if.slave       bus,
  output logic [8*NUM_RW-1:0]   reg_out,
  input  logic [8*NUM_RO-1:0]   status_in,
  output logic [RBCP_DW-1:0]    ctrl_pulse,
  output logic                  access_err
);

  logic [RBCP_AW:0]   diff;
  logic [7:0]         ofs;
  logic               hit;
  logic               strobe;
  logic               pending;
  logic               accept;
  logic               wr_acc;
  logic [RBCP_DW-1:0] scratch;
  logic [RBCP_DW-1:0] rd_data;

  // The extra MSB is the borrow: an address below BASE_ADDR can never hit.
  assign diff   = {1'b0, bus.rbcp_addr} - {1'b0, BASE_ADDR};
  assign hit    = (diff[RBCP_AW:8] == '0);
  assign ofs    = diff[7:0];
  assign strobe = bus.rbcp_act & (bus.rbcp_we | bus.rbcp_re);
  assign accept = strobe & hit & ~pending;
  assign wr_acc = accept & bus.rbcp_we;

  always_comb begin
    rd_data = '0;
    if (!bus.rbcp_we) begin
      case (ofs)
        OFS_ID:      rd_data = ID_VALUE;
        OFS_SCRATCH: rd_data = scratch;
        OFS_ERR:     rd_data = {7'b0, access_err};
        default:     rd_data = '0;
      endcase
      for (int i = 0; i < NUM_RW; i++)
        if (ofs == OFS_RW_BASE + 8'(i)) rd_data = reg_out[8*i +: 8];
      for (int j = 0; j < NUM_RO; j++)
        if (ofs == OFS_RO_BASE + 8'(j)) rd_data = status_in[8*j +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch    <= '0;
      ctrl_pulse <= '0;
      reg_out    <= '0;
      access_err <= 1'b0;
    end else begin
      ctrl_pulse <= '0;
      if (wr_acc) begin
        if (ofs == OFS_SCRATCH) scratch    <= bus.rbcp_wd;
        if (ofs == OFS_CTRL)    ctrl_pulse <= bus.rbcp_wd;
        for (int i = 0; i < NUM_RW; i++)
          if (ofs == OFS_RW_BASE + 8'(i)) reg_out[8*i +: 8] <= bus.rbcp_wd;
      end
      // Set and clear cannot coincide: clearing needs an accept, setting needs pending.
      if (strobe && pending)
        access_err <= 1'b1;
      else if (wr_acc && ofs == OFS_ERR)
        access_err <= 1'b0;
    end
  end

  rbcp_ack_pipe #(.DEPTH(ACK_LATENCY)) u_ack_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (pending & ~bus.rbcp_act),
    .in_valid (accept),
    .in_data  (rd_data),
    .ack      (bus.rbcp_ack),
    .rd       (bus.rbcp_rd),
    .pending  (pending)
  );

endmodule

// File: tb/tb_rbcp_reg_slave.sv
// Bench for rbcp_reg_slave: three configurations share one stimulus source,
// each checked against a register-map reference model.
module tb_rbcp_reg_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        act = 1'b0;
  logic [31:0] addr = '0;
  logic [7:0]  wd = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [31:0] status = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rbcp_reg_slave_if if0 ();
  rbcp_reg_slave_if if1 ();
  rbcp_reg_slave_if if2 ();

  assign if0.rbcp_act = act && (sel == 2'd0);
  assign if1.rbcp_act = act && (sel == 2'd1);
  assign if2.rbcp_act = act && (sel == 2'd2);
  assign if0.rbcp_addr = addr;  assign if1.rbcp_addr = addr;  assign if2.rbcp_addr = addr;
  assign if0.rbcp_wd   = wd;    assign if1.rbcp_wd   = wd;    assign if2.rbcp_wd   = wd;
  assign if0.rbcp_we   = we;    assign if1.rbcp_we   = we;    assign if2.rbcp_we   = we;
  assign if0.rbcp_re   = re;    assign if1.rbcp_re   = re;    assign if2.rbcp_re   = re;

  logic [63:0] reg0, reg1, reg2;
  logic [7:0]  ctl0, ctl1, ctl2;
  logic        err0, err1, err2;

  rbcp_reg_slave #(.BASE_ADDR(32'h0000_0000), .ACK_LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .reg_out(reg0), .status_in(status),
    .ctrl_pulse(ctl0), .access_err(err0));
  rbcp_reg_slave #(.BASE_ADDR(32'h0000_0000), .ACK_LATENCY(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .reg_out(reg1), .status_in(status),
    .ctrl_pulse(ctl1), .access_err(err1));
  rbcp_reg_slave #(.BASE_ADDR(32'hFFFF_FF00), .ACK_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2), .reg_out(reg2), .status_in(status),
    .ctrl_pulse(ctl2), .access_err(err2));

  logic        ack_m, err_m;
  logic [7:0]  rd_m, ctl_m;
  logic [63:0] reg_m;

  always_comb begin
    ack_m = if0.rbcp_ack; rd_m = if0.rbcp_rd; ctl_m = ctl0; reg_m = reg0; err_m = err0;
    if (sel == 2'd1) begin
      ack_m = if1.rbcp_ack; rd_m = if1.rbcp_rd; ctl_m = ctl1; reg_m = reg1; err_m = err1;
    end else if (sel == 2'd2) begin
      ack_m = if2.rbcp_ack; rd_m = if2.rbcp_rd; ctl_m = ctl2; reg_m = reg2; err_m = err2;
    end
  end

  // Reference model state, one copy per configuration
  logic [7:0] m_rw  [3][8];
  logic [7:0] m_scr [3];
  logic       m_err [3];

  function automatic logic [31:0] base_of(input logic [1:0] s);
    return (s == 2'd2) ? 32'hFFFF_FF00 : 32'h0000_0000;
  endfunction

  function automatic int lat_of(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 3 : 2;
  endfunction

  function automatic bit m_hit(input logic [1:0] s, input logic [31:0] a);
    longint d;
    d = longint'({32'b0, a}) - longint'({32'b0, base_of(s)});
    return (d >= 0) && (d <= 255);
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] s, input logic [7:0] o);
    int j;
    if (o == 8'h00) return 8'hA5;
    if (o == 8'h01) return m_scr[s];
    if (o == 8'h03) return {7'b0, m_err[s]};
    if (o >= 8'h10 && o < 8'h18) return m_rw[s][o - 8'h10];
    if (o >= 8'h40 && o < 8'h44) begin
      j = int'(o) - 'h40;
      return status[8*j +: 8];
    end
    return 8'h00;
  endfunction

  function automatic logic [63:0] m_regs(input logic [1:0] s);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = m_rw[s][i];
    return v;
  endfunction

  task automatic m_write(input logic [1:0] s, input logic [7:0] o, input logic [7:0] d);
    if (o == 8'h01) m_scr[s] = d;
    if (o == 8'h03) m_err[s] = 1'b0;
    if (o >= 8'h10 && o < 8'h18) m_rw[s][o - 8'h10] = d;
  endtask

  task automatic reset_models();
    for (int s = 0; s < 3; s++) begin
      m_scr[s] = 8'h00;
      m_err[s] = 1'b0;
      for (int i = 0; i < 8; i++) m_rw[s][i] = 8'h00;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access with act held through the whole ack window
  task automatic xfer(input logic [1:0] s, input bit w, input bit r,
                      input logic [31:0] a, input logic [7:0] d);
    bit         hit;
    logic [7:0] o, exp_rd, exp_ctl;
    int         lat;
    hit     = m_hit(s, a);
    o       = 8'(a - base_of(s));
    lat     = lat_of(s);
    exp_rd  = (hit && r && !w) ? m_read(s, o) : 8'h00;
    exp_ctl = (hit && w && o == 8'h02) ? d : 8'h00;
    if (hit && w) m_write(s, o, d);
    sel = s;
    @(posedge clk); #1 act = 1'b1; addr = a; wd = d; we = w; re = r;
    @(posedge clk); #1 we = 1'b0; re = 1'b0;
    for (int k = 1; k <= lat + 2; k++) begin
      @(negedge clk);
      chk("ack", {63'b0, ack_m}, {63'b0, hit && k == lat});
      chk("rd", {56'b0, rd_m}, {56'b0, (hit && k == lat) ? exp_rd : 8'h00});
      if (k == 1) begin
        chk("reg_out", reg_m, m_regs(s));
        chk("ctrl_pulse", {56'b0, ctl_m}, {56'b0, exp_ctl});
      end
      if (k == 2) chk("ctrl_clear", {56'b0, ctl_m}, 64'h0);
      @(posedge clk);
    end
    #1 act = 1'b0;
    chk("access_err", {63'b0, err_m}, {63'b0, m_err[s]});
  endtask

  int          kind, rw;
  logic [7:0]  o_r;
  logic [31:0] a_r;

  initial begin
    reset_models();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ack", {63'b0, ack_m}, 64'h0);
    chk("rst_rd", {56'b0, rd_m}, 64'h0);
    chk("rst_reg_out", reg_m, 64'h0);
    chk("rst_ctrl", {56'b0, ctl_m}, 64'h0);
    chk("rst_err", {63'b0, err_m}, 64'h0);

    xfer(2'd0, 1'b0, 1'b1, 32'h00, 8'h00);
    xfer(2'd0, 1'b1, 1'b0, 32'h11, 8'h5C);
    chk("reg_byte1", {56'b0, reg0[15:8]}, 64'h5C);
    xfer(2'd0, 1'b0, 1'b1, 32'h11, 8'h00);
    xfer(2'd0, 1'b1, 1'b0, 32'h02, 8'h81);
    xfer(2'd0, 1'b0, 1'b1, 32'h02, 8'h00);

    // Back-to-back RE with latency 3: only the first is served
    sel = 2'd1;
    m_err[1] = 1'b1;
    @(posedge clk); #1 act = 1'b1; addr = 32'h00; re = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("dbl_ack", {63'b0, ack_m}, {63'b0, k == 3});
      chk("dbl_rd", {56'b0, rd_m}, {56'b0, (k == 3) ? 8'hA5 : 8'h00});
      @(posedge clk); #1 re = 1'b0;
    end
    act = 1'b0;
    chk("dbl_err", {63'b0, err_m}, 64'h1);
    xfer(2'd1, 1'b0, 1'b1, 32'h03, 8'h00);
    xfer(2'd1, 1'b1, 1'b0, 32'h03, 8'($urandom));

    // Abort: act falls one cycle after an accepted write
    m_rw[1][0] = 8'h6E;
    @(posedge clk); #1 act = 1'b1; addr = 32'h10; wd = 8'h6E; we = 1'b1;
    @(posedge clk); #1 we = 1'b0; act = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("abort_ack", {63'b0, ack_m}, 64'h0);
      if (k == 1) chk("abort_reg", {56'b0, reg1[7:0]}, 64'h6E);
      @(posedge clk);
    end

    // Reset while an ack is pending
    @(posedge clk); #1 act = 1'b1; addr = 32'h01; re = 1'b1;
    @(posedge clk); #1 re = 1'b0; rst_n = 1'b0;
    #1;
    chk("rstmid_ack", {63'b0, ack_m}, 64'h0);
    chk("rstmid_rd", {56'b0, rd_m}, 64'h0);
    chk("rstmid_reg", reg_m, 64'h0);
    chk("rstmid_err", {63'b0, err_m}, 64'h0);
    reset_models();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("rstmid_noack", {63'b0, ack_m}, 64'h0);
      @(posedge clk);
    end
    #1 act = 1'b0;

    // High base address: no wrap into a false hit
    status = 32'h0000_003C;
    xfer(2'd2, 1'b0, 1'b1, 32'h0000_0005, 8'h00);
    xfer(2'd2, 1'b0, 1'b1, 32'hFFFF_FF40, 8'h00);
    xfer(2'd2, 1'b0, 1'b1, 32'hFFFF_FF7F, 8'h00);

    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 40; n++) begin
        kind = int'($urandom_range(0, 9));
        case (kind)
          0: o_r = 8'h00;
          1: o_r = 8'h01;
          2: o_r = 8'h02;
          3: o_r = 8'h03;
          4: o_r = 8'h10 + 8'($urandom_range(0, 7));
          5: o_r = 8'h18 + 8'($urandom_range(0, 7));
          6: o_r = 8'h40 + 8'($urandom_range(0, 3));
          7: o_r = 8'h44;
          default: o_r = 8'($urandom);
        endcase
        a_r = base_of(2'(s)) + {24'b0, o_r};
        if (kind == 9)
          a_r = ($urandom_range(0, 1) == 1) ? base_of(2'(s)) - 32'($urandom_range(1, 16))
                                            : base_of(2'(s)) + 32'h100 + 32'($urandom_range(0, 16));
        rw = int'($urandom_range(1, 3));
        status = $urandom;
        xfer(2'(s), rw[0], rw[1], a_r, 8'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
